// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and arithmetic helpers for the fully connected layer engine
// Contents: fc_state_e FSM encoding, clog2 constant helper, fmul fixed-point product.
// Optional feature macro used by importers: FC_SAT_EN (saturating arithmetic).
package fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR  = 2'd1,
        ST_EMIT = 2'd2,
        ST_UPD  = 2'd3
    } fc_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int n = 1; n < value; n = n * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Full-precision product shifted back to the fixed-point scale; the caller
    // narrows it to its word width (truncating or saturating).
    function automatic logic signed [63:0] fmul(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input int frac_w);
        logic signed [63:0] p;
        // Low 64 bits of the product are sign-independent once both operands
        // are sign-extended, so an unsigned multiply is exact here.
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p >>> frac_w;
    endfunction

endpackage

// File: rtl/fc_mac.sv
// rtl/fc_mac.sv - fixed-point multiply, arithmetic right shift and accumulate
// Ports: a_i, b_i operands (DATA_W); acc_i running sum (ACC_W); sum_o = acc_i + (fmul(a_i,b_i) >>> SHIFT).
// Macro FC_SAT_EN: saturate the product to DATA_W and the sum to ACC_W instead of wrapping.
module fc_mac
    import fc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [DATA_W-1:0] fm;
    logic signed [DATA_W-1:0] term;

`ifdef FC_SAT_EN
    localparam logic signed [63:0] D_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [63:0] D_MIN = -(64'sd1 <<< (DATA_W - 1));

    logic signed [63:0]    prod;
    logic signed [ACC_W:0] sum_wide;

    always_comb begin
        prod = fmul(32'(a_i), 32'(b_i), FRAC_W);
        if (prod > D_MAX) begin
            fm = D_MAX[DATA_W-1:0];
        end else if (prod < D_MIN) begin
            fm = D_MIN[DATA_W-1:0];
        end else begin
            fm = prod[DATA_W-1:0];
        end
        term = fm >>> SHIFT;
        // One guard bit exposes overflow as a disagreement of the top two bits.
        sum_wide = {acc_i[ACC_W-1], acc_i} + (ACC_W + 1)'(term);
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_o = sum_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            sum_o = sum_wide[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        fm    = DATA_W'(fmul(32'(a_i), 32'(b_i), FRAC_W));
        term  = fm >>> SHIFT;
        sum_o = acc_i + ACC_W'(term);
    end
`endif

endmodule

// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - fully connected layer back-propagation and batch weight update engine
// Ports: clk, reset_n (sync, active-low); host we/wsel/addr/wdata -> rdata (registered);
//        bp_start -> bp_busy, err_valid/err_data/err_addr stream, bp_done; upd_start -> upd_done.
// Macro FC_SAT_EN: saturating arithmetic; default build wraps two's-complement.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int IN_CELL    = 32,
    parameter int OUT_CELL   = 10,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int BATCH_SIZE = 32,
    parameter int LR_SHIFT   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [1:0]        wsel,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              bp_start,
    output logic              bp_busy,
    output logic              bp_done,
    output logic              err_valid,
    output logic [DATA_W-1:0] err_data,
    output logic [15:0]       err_addr,
    input  logic              upd_start,
    output logic              upd_done
);

    localparam int LOG2_B = clog2(BATCH_SIZE);
    localparam int ACC_W  = DATA_W + LOG2_B;
    localparam int N_W    = IN_CELL * OUT_CELL;
    localparam int IW     = (IN_CELL > 1) ? clog2(IN_CELL) : 1;
    localparam int OW     = (OUT_CELL > 1) ? clog2(OUT_CELL) : 1;
    localparam int KW     = (N_W > 1) ? clog2(N_W) : 1;

    fc_state_e state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [OW-1:0] o_q, o_d;
    logic [KW-1:0] k_q, k_d;
    logic bp_done_q, upd_done_q;
    logic [DATA_W-1:0] rdata_q, rd_val;

    logic signed [DATA_W-1:0] act_q  [IN_CELL];
    logic signed [DATA_W-1:0] w_q    [N_W];
    logic signed [DATA_W-1:0] err_q  [OUT_CELL];
    logic signed [DATA_W-1:0] perr_q [IN_CELL];
    logic signed [ACC_W-1:0]  dacc_q [N_W];

    logic signed [DATA_W-1:0] perr_acc, perr_sum, dw, w_new;
    logic signed [ACC_W-1:0]  dacc_sum;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        o_d     = o_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                i_d = '0;
                o_d = '0;
                k_d = '0;
                if (bp_start) begin
                    state_d = ST_ERR;
                end else if (upd_start) begin
                    state_d = ST_UPD;
                end
            end
            ST_ERR: begin
                // k tracks o*IN_CELL+i so the weight/delta index needs no multiplier.
                k_d = k_q + KW'(1);
                if (i_q == IW'(IN_CELL - 1)) begin
                    i_d = '0;
                    if (o_q == OW'(OUT_CELL - 1)) begin
                        o_d     = '0;
                        k_d     = '0;
                        state_d = ST_EMIT;
                    end else begin
                        o_d = o_q + OW'(1);
                    end
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            ST_EMIT: begin
                if (i_q == IW'(IN_CELL - 1)) begin
                    i_d     = '0;
                    state_d = ST_IDLE;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            ST_UPD: begin
                if (k_q == KW'(N_W - 1)) begin
                    k_d     = '0;
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (wsel)
            2'd0: if (addr < 16'(IN_CELL))  rd_val = act_q[addr[IW-1:0]];
            2'd1: if (addr < 16'(N_W))      rd_val = w_q[addr[KW-1:0]];
            2'd2: if (addr < 16'(OUT_CELL)) rd_val = err_q[addr[OW-1:0]];
            default: if (addr < 16'(IN_CELL)) rd_val = perr_q[addr[IW-1:0]];
        endcase
    end

    // The first output row starts a fresh propagated-error sum.
    assign perr_acc = (o_q == '0) ? '0 : perr_q[i_q];

    fc_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(DATA_W), .SHIFT(0)) u_mac_err (
        .a_i  (w_q[k_q]),
        .b_i  (err_q[o_q]),
        .acc_i(perr_acc),
        .sum_o(perr_sum)
    );

    fc_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .SHIFT(LR_SHIFT)) u_mac_delta (
        .a_i  (err_q[o_q]),
        .b_i  (act_q[i_q]),
        .acc_i(dacc_q[k_q]),
        .sum_o(dacc_sum)
    );

    // Dividing by the batch size leaves exactly DATA_W significant bits.
    assign dw = DATA_W'(dacc_q[k_q] >>> LOG2_B);

`ifdef FC_SAT_EN
    logic signed [DATA_W:0] w_wide;
    always_comb begin
        w_wide = {w_q[k_q][DATA_W-1], w_q[k_q]} + {dw[DATA_W-1], dw};
        if (w_wide[DATA_W] != w_wide[DATA_W-1]) begin
            w_new = w_wide[DATA_W] ? {1'b1, {(DATA_W - 1){1'b0}}} : {1'b0, {(DATA_W - 1){1'b1}}};
        end else begin
            w_new = w_wide[DATA_W-1:0];
        end
    end
`else
    assign w_new = w_q[k_q] + dw;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            o_q        <= '0;
            k_q        <= '0;
            bp_done_q  <= 1'b0;
            upd_done_q <= 1'b0;
            rdata_q    <= '0;
            for (int n = 0; n < N_W; n++) begin
                dacc_q[n] <= '0;
            end
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            o_q        <= o_d;
            k_q        <= k_d;
            bp_done_q  <= (state_q == ST_EMIT) && (state_d == ST_IDLE);
            upd_done_q <= (state_q == ST_UPD) && (state_d == ST_IDLE);
            rdata_q    <= rd_val;
            if (state_q == ST_ERR) begin
                dacc_q[k_q] <= dacc_sum;
            end else if (state_q == ST_UPD) begin
                dacc_q[k_q] <= '0;
            end
        end
    end

    // Data memories keep their contents through reset; the reset edge itself
    // performs no write so an aborted pass leaves earlier results in place.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == ST_IDLE && we) begin
                case (wsel)
                    2'd0: if (addr < 16'(IN_CELL))  act_q[addr[IW-1:0]] <= wdata;
                    2'd1: if (addr < 16'(N_W))      w_q[addr[KW-1:0]]   <= wdata;
                    2'd2: if (addr < 16'(OUT_CELL)) err_q[addr[OW-1:0]] <= wdata;
                    default: ;
                endcase
            end
            if (state_q == ST_ERR) begin
                perr_q[i_q] <= perr_sum;
            end
            if (state_q == ST_UPD) begin
                w_q[k_q] <= w_new;
            end
        end
    end

    assign rdata     = rdata_q;
    assign bp_busy   = (state_q == ST_ERR) || (state_q == ST_EMIT);
    assign bp_done   = bp_done_q;
    assign upd_done  = upd_done_q;
    assign err_valid = (state_q == ST_EMIT);
    assign err_data  = err_valid ? perr_q[i_q] : '0;
    assign err_addr  = err_valid ? 16'(i_q) : '0;

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb/tb_fc_layer_engine.sv - self-checking bench for fc_layer_engine against an array-based reference model
module tb_fc_layer_engine;

    localparam int IN = 2, OUT = 2, NW = 4, DW = 16, FRAC = 8, BATCH = 2, LR = 1;
    localparam int LOG2B = 1, ACCW = 17;
    localparam int BP_LAT = NW + IN + 1;
    localparam int UPD_LAT = NW + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0, we = 1'b0, bp_start = 1'b0, upd_start = 1'b0;
    logic [1:0] wsel = 2'd0;
    logic [15:0] addr = 16'd0;
    logic [DW-1:0] wdata = '0;
    logic signed [DW-1:0] rdata, err_data;
    logic bp_busy, bp_done, err_valid, upd_done;
    logic [15:0] err_addr;

    int n_checks = 0;
    int n_errors = 0;

    longint m_act[IN], m_w[NW], m_err[OUT], m_perr[IN], m_dacc[NW];

    always #5 clk = ~clk;

    fc_layer_engine #(
        .IN_CELL(IN), .OUT_CELL(OUT), .DATA_W(DW), .FRAC_W(FRAC),
        .BATCH_SIZE(BATCH), .LR_SHIFT(LR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wsel(wsel), .addr(addr),
        .wdata(wdata), .rdata(rdata), .bp_start(bp_start), .bp_busy(bp_busy),
        .bp_done(bp_done), .err_valid(err_valid), .err_data(err_data),
        .err_addr(err_addr), .upd_start(upd_start), .upd_done(upd_done)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Fit an exact integer into a signed field of the given width.
    function automatic longint fit(input longint v, input int w);
        longint lo, hi, m;
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
`ifdef FC_SAT_EN
        m = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        m = v & ((longint'(1) << w) - 1);
        if (m > hi) m = m - (longint'(1) << w);
`endif
        return m;
    endfunction

    function automatic longint fmul_m(input longint a, input longint b);
        return fit((a * b) >>> FRAC, DW);
    endfunction

    task automatic model_bp();
        for (int o = 0; o < OUT; o++) begin
            for (int i = 0; i < IN; i++) begin
                m_perr[i] = fit(((o == 0) ? 0 : m_perr[i]) + fmul_m(m_w[o*IN+i], m_err[o]), DW);
                m_dacc[o*IN+i] = fit(m_dacc[o*IN+i] + (fmul_m(m_err[o], m_act[i]) >>> LR), ACCW);
            end
        end
    endtask

    task automatic model_upd();
        for (int k = 0; k < NW; k++) begin
            m_w[k] = fit(m_w[k] + (m_dacc[k] >>> LOG2B), DW);
            m_dacc[k] = 0;
        end
    endtask

    task automatic wr(input logic [1:0] s, input int a, input longint d);
        @(negedge clk);
        we = 1'b1; wsel = s; addr = 16'(a); wdata = DW'(d);
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, input int a, output longint v);
        @(negedge clk);
        we = 1'b0; wsel = s; addr = 16'(a);
        @(posedge clk); #1;
        v = rdata;
    endtask

    task automatic load(input longint act[IN], input longint w[NW], input longint e[OUT]);
        for (int i = 0; i < IN; i++) begin wr(2'd0, i, act[i]); m_act[i] = fit(act[i], DW); end
        for (int k = 0; k < NW; k++) begin wr(2'd1, k, w[k]); m_w[k] = fit(w[k], DW); end
        for (int o = 0; o < OUT; o++) begin wr(2'd2, o, e[o]); m_err[o] = fit(e[o], DW); end
    endtask

    task automatic do_bp(input bit also_upd, input bit write_mid);
        int done_at, ndone, nupd, nvalid;
        longint got[$];
        done_at = -1; ndone = 0; nupd = 0; nvalid = 0;
        model_bp();
        @(negedge clk);
        bp_start = 1'b1; upd_start = also_upd;
        for (int c = 1; c <= BP_LAT + 3; c++) begin
            @(posedge clk); #1;
            bp_start = 1'b0; upd_start = 1'b0;
            if (c == 1) check_eq("bp_busy_first", bp_busy, 1);
            if (c == BP_LAT) check_eq("bp_busy_end", bp_busy, 0);
            if (write_mid && c == 2) begin
                we = 1'b1; wsel = 2'd1; addr = 16'd0; wdata = 16'h1234;
            end else begin
                we = 1'b0;
            end
            if (err_valid) begin
                check_eq("err_addr", err_addr, nvalid);
                got.push_back(err_data);
                nvalid++;
            end
            if (bp_done) begin ndone++; done_at = c; end
            if (upd_done) nupd++;
        end
        check_eq("err_count", nvalid, IN);
        for (int i = 0; i < IN && i < got.size(); i++) check_eq("err_data", got[i], m_perr[i]);
        check_eq("bp_done_count", ndone, 1);
        check_eq("bp_done_at", done_at, BP_LAT);
        check_eq("no_upd_done", nupd, 0);
    endtask

    task automatic do_upd(input bit poke);
        int done_at, ndone, busy;
        done_at = -1; ndone = 0; busy = 0;
        model_upd();
        @(negedge clk);
        upd_start = 1'b1;
        for (int c = 1; c <= UPD_LAT + 3; c++) begin
            @(posedge clk); #1;
            upd_start = 1'b0;
            bp_start = poke && (c == 2);
            if (bp_busy) busy++;
            if (upd_done) begin ndone++; done_at = c; end
        end
        bp_start = 1'b0;
        check_eq("upd_done_count", ndone, 1);
        check_eq("upd_done_at", done_at, UPD_LAT);
        check_eq("bp_ignored_in_upd", busy, 0);
    endtask

    task automatic check_weights(input string tag);
        longint v;
        for (int k = 0; k < NW; k++) begin
            rd(2'd1, k, v);
            check_eq(tag, v, m_w[k]);
        end
    endtask

    function automatic longint rnd_word();
        if ($urandom_range(0, 3) == 0) return longint'($urandom_range(0, 65535)) - 32768;
        return longint'($urandom_range(0, 2047)) - 1024;
    endfunction

    initial begin
        longint v;
        longint a_t[IN], w_t[NW], e_t[OUT];
        int ndone;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bp_busy", bp_busy, 0);
        check_eq("rst_bp_done", bp_done, 0);
        check_eq("rst_upd_done", upd_done, 0);
        check_eq("rst_err_valid", err_valid, 0);
        check_eq("rst_err_data", err_data, 0);
        check_eq("rst_err_addr", err_addr, 0);
        check_eq("rst_rdata", rdata, 0);
        for (int k = 0; k < NW; k++) m_dacc[k] = 0;
        @(negedge clk);
        reset_n = 1'b1;

        // Two-by-two propagation example, run twice, then a batch update.
        a_t = '{256, 512};
        w_t = '{256, 0, 0, 256};
        e_t = '{256, -256};
        load(a_t, w_t, e_t);
        do_bp(1'b0, 1'b0);
        rd(2'd3, 0, v); check_eq("perr0_example", v, 256);
        rd(2'd3, 1, v); check_eq("perr1_example", v, -256);
        do_bp(1'b0, 1'b0);
        do_upd(1'b0);
        rd(2'd1, 0, v); check_eq("w00_after_upd", v, 384);
        rd(2'd1, 1, v); check_eq("w01_after_upd", v, 256);
        rd(2'd1, 2, v); check_eq("w10_after_upd", v, -128);
        rd(2'd1, 3, v); check_eq("w11_after_upd", v, 0);
        do_upd(1'b1);
        check_weights("w_zero_dacc_upd");

        // Product overflow in the propagated-error path.
        w_t = '{32767, 0, 0, 0};
        e_t = '{512, 0};
        load(a_t, w_t, e_t);
        do_bp(1'b0, 1'b0);
        rd(2'd3, 0, v);
`ifdef FC_SAT_EN
        check_eq("perr_sat", v, 32767);
`else
        check_eq("perr_wrap", v, -2);
`endif

        // Simultaneous requests plus a host write while busy.
        do_bp(1'b1, 1'b1);
        rd(2'd1, 0, v); check_eq("write_in_err_ignored", v, m_w[0]);

        // Read-only region and out-of-range addresses.
        wr(2'd3, 0, 1111);
        rd(2'd3, 0, v); check_eq("perr_readonly", v, m_perr[0]);
        wr(2'd1, NW, 77);
        rd(2'd1, NW, v); check_eq("w_oor_read", v, 0);
        rd(2'd0, IN, v); check_eq("act_oor_read", v, 0);
        rd(2'd2, OUT + 3, v); check_eq("err_oor_read", v, 0);
        rd(2'd3, IN, v); check_eq("perr_oor_read", v, 0);

        // Reset during the third ERR cycle aborts the pass and clears deltas.
        @(negedge clk);
        bp_start = 1'b1;
        @(posedge clk); #1; bp_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset_n = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_bp_busy", bp_busy, 0);
        reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < BP_LAT + 3; c++) begin
            @(posedge clk); #1;
            if (bp_done) ndone++;
        end
        check_eq("abort_no_bp_done", ndone, 0);
        for (int k = 0; k < NW; k++) m_dacc[k] = 0;
        do_upd(1'b0);
        check_weights("w_after_abort_upd");

        // Randomized passes with periodic batch updates.
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < IN; i++) a_t[i] = rnd_word();
            for (int k = 0; k < NW; k++) w_t[k] = rnd_word();
            for (int o = 0; o < OUT; o++) e_t[o] = rnd_word();
            load(a_t, w_t, e_t);
            do_bp(1'b0, 1'b0);
            if (it % 2 == 1) begin
                do_upd(1'b0);
                check_weights("w_rand_upd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL expose the following parameters:
- IN_CELL, 32, input (front) neurons.
- OUT_CELL, 10, output (back) neurons.
- DATA_W, 16, signed fixed-point word width.
- FRAC_W, 8, fractional bits.
- BATCH_SIZE, 32, samples per mini-batch; power of two.
- LR_SHIFT, 5, learning rate expressed as a right shift.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL expose the following ports, clock and reset first:
- clk, in, 1, single clock.
- reset_n, in, 1, synchronous active-low reset.
- we, in, 1, host write enable.
- wsel, in, 2, region select: 0 activation, 1 weight, 2 output error, 3 propagated error (read-only).
- addr, in, 16, word address within the selected region; weight index = o*IN_CELL+i.
- wdata, in, DATA_W, host write data.
- rdata, out, DATA_W, read data, registered.
- bp_start, in, 1, back-propagation request pulse.
- bp_busy, out, 1, back-propagation in progress.
- bp_done, out, 1, one-cycle pulse.
- err_valid, out, 1, propagated-error stream valid.
- err_data, out, DATA_W, propagated-error stream data.
- err_addr, out, 16, propagated-error stream index.
- upd_start, in, 1, batch-end weight update request pulse.
- upd_done, out, 1, one-cycle pulse.
REQ-003 Clocking and reset SHALL be: one clock clk; reset_n synchronous, active-low.

Function
REQ-004 fmul(a,b) SHALL be (a*b)>>>FRAC_W, computed at 2*DATA_W and truncated to DATA_W (saturated per REQ-019).
REQ-005 Reads SHALL update rdata one cycle after addr/wsel, in any state; an out-of-range address SHALL read 0.
REQ-006 Writes SHALL be accepted only in IDLE; writes to wsel=3 or out-of-range addresses SHALL be ignored.
REQ-007 The FSM SHALL have states IDLE, ERR, EMIT, UPD; IDLE→ERR on bp_start, IDLE→UPD on upd_start, and bp_start wins if both are asserted in the same cycle.
REQ-008 ERR SHALL iterate o=0..OUT_CELL-1 (outer) and i=0..IN_CELL-1 (inner), one (o,i) per cycle:
- perr[i] = (o==0 ? 0 : perr[i]) + fmul(w[o][i], err[o]).
- dacc[o][i] += fmul(err[o], act[i]) >>> LR_SHIFT.
REQ-009 EMIT SHALL drive err_valid=1 with err_data=perr[i] and err_addr=i for i=0..IN_CELL-1 on consecutive cycles, then return to IDLE and pulse bp_done in the first IDLE cycle.
REQ-010 bp_busy SHALL be high in ERR and EMIT; bp_done SHALL occur exactly OUT_CELL*IN_CELL+IN_CELL+1 cycles after the bp_start cycle.
REQ-011 dacc entries SHALL be ACC_W = DATA_W+log2(BATCH_SIZE) bits wide and wrap-free for BATCH_SIZE accumulations.
REQ-012 UPD SHALL process one index k=0..IN_CELL*OUT_CELL-1 per cycle: w[k] += dacc[k]>>>log2(BATCH_SIZE), then dacc[k]=0; it SHALL return to IDLE and pulse upd_done OUT_CELL*IN_CELL+1 cycles after upd_start.
REQ-013 bp_start or upd_start while not in IDLE SHALL be ignored (not queued).
REQ-014 An UPD with all dacc=0 SHALL leave the weights unchanged.
REQ-015 Outputs err_valid, bp_done and upd_done SHALL be high for exactly one cycle per element or event.

Reset
REQ-016 While reset_n=0 at a clk edge, the block SHALL set: state=IDLE, counters=0, bp_busy=0, bp_done=0, upd_done=0, err_valid=0, err_data=0, err_addr=0, rdata=0.
REQ-017 Reset SHALL clear all dacc entries; activations, weights, err and perr are not reset.
REQ-018 Reset asserted mid-ERR/EMIT/UPD SHALL abort the operation with no done pulse; weights partially updated before the abort remain as written.

Configuration
REQ-019 With FC_SAT_EN defined, fmul, perr accumulation, dacc accumulation and weight update SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (ACC_W range for dacc); without FC_SAT_EN they SHALL wrap two's-complement.

Structure
REQ-020 Package fc_pkg SHALL hold the fmul function, the FSM state enum, and a clog2 helper constant function.
REQ-021 One sub-module, fc_mac (multiply, shift, add with optional saturation), SHALL be instantiated twice: once for the error path and once for the delta path.

Verification
REQ-022 Propagation: IN_CELL=2, OUT_CELL=2, FRAC_W=8, LR_SHIFT=1; act=[256,512], w=[[256,0],[0,256]], err=[256,-256]; bp_start → err stream (0,256),(1,-256); bp_done 7 cycles after bp_start.
REQ-023 Batch update: the REQ-022 sample run twice with BATCH_SIZE=2, then upd_start → w=[[384,256],[-128,0]]; dacc all 0; upd_done 5 cycles after upd_start.
REQ-024 Saturation: w[0][0]=0x7FFF, err[0]=512, other entries 0 → perr[0]=0x7FFF with FC_SAT_EN, 0xFFFE without.
REQ-025 Collision: bp_start and upd_start in the same IDLE cycle → ERR entered, upd_start dropped, no upd_done; a write during ERR leaves memory unchanged.
REQ-026 Reset abort: reset_n low for 1 cycle at the 3rd ERR cycle → bp_busy=0 next cycle, no bp_done, dacc reads as 0 after a subsequent UPD leaves weights unchanged.
